led_output_scheduler: RTL and testbench

Owns the board LED bank and shares it between two sources: the Nios LED PIO word and an internal 8-bit-class PWM brightness generator. A debounced slide switch picks the source. Source changes and new duty values take effect only on a PWM period boundary, so the LEDs never show a runt pulse or a half-switched word. The block sits in the top level between the Nios system outputs and the LED pins.

---
 rtl/led_sched_pkg.sv | 26 ++
 rtl/switch_debouncer.sv | 52 +++++
 rtl/led_output_scheduler.sv | 136 +++++++++++++
 tb/tb_led_output_scheduler.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_sched_pkg.sv
// Shared types and constants for the LED output scheduler and its switch debouncer.
package led_sched_pkg;

    // Source-selection state machine: two settled states and two pending states
    // that keep driving the old source until the next PWM wrap.
    typedef enum logic [1:0] {
        S_PWM     = 2'd0,
        S_NIOS    = 2'd1,
        S_TO_NIOS = 2'd2,
        S_TO_PWM  = 2'd3
    } sched_state_t;

    localparam logic MODE_NIOS = 1'b1;
    localparam logic MODE_PWM  = 1'b0;

    // 20 ms at 50 MHz.
    localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;

    localparam int LED_WIDTH = 8;

    // Replicate the PWM level across the whole LED bank.
    function automatic logic [LED_WIDTH-1:0] pwm_fill(input logic level);
        return {LED_WIDTH{level}};
    endfunction

endpackage

// File: rtl/switch_debouncer.sv
// Two-flop synchronizer followed by a stability counter; sw_stable only follows
// the synchronized input after it has disagreed for DEBOUNCE_CYCLES edges in a row.
module switch_debouncer
    import led_sched_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic sw_raw,
    output logic sw_stable
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic          sync_meta_r;
    logic          sw_sync_r;
    logic          sw_stable_r;
    logic [CW-1:0] db_cnt_r;

    // Bring the raw switch into the clock domain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_meta_r <= 1'b0;
            sw_sync_r   <= 1'b0;
        end else begin
            sync_meta_r <= sw_raw;
            sw_sync_r   <= sync_meta_r;
        end
    end

    // Count consecutive disagreement; accept the new level once it has held long enough.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            db_cnt_r    <= CNT_ZERO;
            sw_stable_r <= 1'b0;
        end else if (sw_sync_r == sw_stable_r) begin
            db_cnt_r    <= CNT_ZERO;
        end else if (db_cnt_r == CNT_LAST) begin
            db_cnt_r    <= CNT_ZERO;
            sw_stable_r <= sw_sync_r;
        end else begin
            db_cnt_r    <= db_cnt_r + CNT_ONE;
        end
    end

    assign sw_stable = sw_stable_r;

endmodule

// File: rtl/led_output_scheduler.sv
// Shares the LED bank between the Nios PIO word and a PWM brightness generator.
// Source and duty changes are only applied on the PWM wrap so no runt pulse or
// half-switched word ever reaches the pins.
module led_output_scheduler
    import led_sched_pkg::*;
#(
    parameter int PWM_WIDTH       = 8,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sw_sel,
    input  logic [PWM_WIDTH-1:0] duty,
    input  logic [7:0]           nios_leds,
    output logic [7:0]           leds,
    output logic                 pwm_out,
    output logic                 period_start,
    output logic                 mode
);

    localparam logic [PWM_WIDTH-1:0] CNT_MAX  = {PWM_WIDTH{1'b1}};
    localparam logic [PWM_WIDTH-1:0] CNT_ZERO = {PWM_WIDTH{1'b0}};
    localparam logic [PWM_WIDTH-1:0] CNT_ONE  = PWM_WIDTH'(1);

    logic                 sw_stable_s;
    logic                 wrap_s;
    logic                 pwm_next_s;
    logic [7:0]           leds_next_s;
    logic [PWM_WIDTH-1:0] cnt_r;
    logic [PWM_WIDTH-1:0] duty_q_r;
    sched_state_t         state_r;
    logic                 mode_r;
    logic [7:0]           leds_r;
    logic                 pwm_r;
    logic                 period_start_r;

    switch_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_sel_debouncer (
        .clk      (clk),
        .reset    (reset),
        .sw_raw   (sw_sel),
        .sw_stable(sw_stable_s)
    );

    assign wrap_s = (cnt_r == CNT_MAX);

    // Free-running period counter; the duty request is latched only at the wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r    <= CNT_ZERO;
            duty_q_r <= CNT_ZERO;
        end else begin
            cnt_r <= cnt_r + CNT_ONE;
            if (wrap_s) begin
                duty_q_r <= duty;
            end else begin
                duty_q_r <= duty_q_r;
            end
        end
    end

    // Source selection: a stable switch change parks in a pending state, and the
    // applied mode only flips on the wrap edge while the request still holds.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= S_PWM;
            mode_r  <= MODE_PWM;
        end else begin
            case (state_r)
                S_PWM: begin
                    if (sw_stable_s == MODE_NIOS) state_r <= S_TO_NIOS;
                    else                          state_r <= S_PWM;
                end
                S_NIOS: begin
                    if (sw_stable_s == MODE_PWM) state_r <= S_TO_PWM;
                    else                         state_r <= S_NIOS;
                end
                S_TO_NIOS: begin
                    if (sw_stable_s != MODE_NIOS) begin
                        state_r <= S_PWM;
                    end else if (wrap_s) begin
                        state_r <= S_NIOS;
                        mode_r  <= MODE_NIOS;
                    end else begin
                        state_r <= S_TO_NIOS;
                    end
                end
                S_TO_PWM: begin
                    if (sw_stable_s != MODE_PWM) begin
                        state_r <= S_NIOS;
                    end else if (wrap_s) begin
                        state_r <= S_PWM;
                        mode_r  <= MODE_PWM;
                    end else begin
                        state_r <= S_TO_PWM;
                    end
                end
                default: begin
                    state_r <= S_PWM;
                    mode_r  <= MODE_PWM;
                end
            endcase
        end
    end

    // Next values for the pin registers, derived from the applied mode and duty.
    always_comb begin
        pwm_next_s  = (cnt_r < duty_q_r);
        leds_next_s = 8'h00;
        if (mode_r == MODE_NIOS) begin
            leds_next_s = nios_leds;
        end else begin
            leds_next_s = pwm_fill(pwm_next_s);
        end
    end

    // Pin registers: everything the board sees changes on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            leds_r         <= 8'h00;
            pwm_r          <= 1'b0;
            period_start_r <= 1'b0;
        end else begin
            leds_r         <= leds_next_s;
            pwm_r          <= pwm_next_s;
            period_start_r <= (cnt_r == CNT_ZERO);
        end
    end

    assign leds         = leds_r;
    assign pwm_out      = pwm_r;
    assign period_start = period_start_r;
    assign mode         = mode_r;

endmodule

// File: tb/tb_led_output_scheduler.sv
// Self-checking bench for led_output_scheduler with PWM_WIDTH=4, DEBOUNCE_CYCLES=4.
module tb_led_output_scheduler;

    localparam int PW     = 4;
    localparam int DB     = 4;
    localparam int PERIOD = 16;

    logic          clk       = 1'b0;
    logic          reset     = 1'b1;
    logic          sw_sel    = 1'b0;
    logic [PW-1:0] duty      = 4'd0;
    logic [7:0]    nios_leds = 8'h00;
    logic [7:0]    leds;
    logic          pwm_out;
    logic          period_start;
    logic          mode;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: edges since reset release, input history, and the
    // applied mode/duty as seen by the specification's rules.
    int         m_edges;
    bit         m_stable;
    bit         m_prev_stable;
    bit         m_mode;
    int         m_dq;
    bit         sel_q[$];
    bit         sync_q[$];
    logic [7:0] exp_leds;
    logic       exp_pwm;
    logic       exp_ps;
    logic       exp_mode;

    always #5 clk = ~clk;

    led_output_scheduler #(
        .PWM_WIDTH      (PW),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sw_sel      (sw_sel),
        .duty        (duty),
        .nios_leds   (nios_leds),
        .leds        (leds),
        .pwm_out     (pwm_out),
        .period_start(period_start),
        .mode        (mode)
    );

    task automatic model_reset();
        m_edges = 0; m_stable = 1'b0; m_prev_stable = 1'b0; m_mode = 1'b0; m_dq = 0;
        sel_q.delete(); sync_q.delete();
        exp_leds = 8'h00; exp_pwm = 1'b0; exp_ps = 1'b0; exp_mode = 1'b0;
    endtask

    // Advance the model across one clock edge using the inputs currently applied.
    task automatic model_edge();
        bit sync_v;
        bit flip;
        int p;
        sync_v = (sel_q.size() >= 2) ? sel_q[sel_q.size()-2] : 1'b0;
        sel_q.push_back(sw_sel);
        sync_q.push_back(sync_v);
        p = m_edges % PERIOD;
        exp_pwm  = (p < m_dq);
        exp_ps   = (p == 0);
        exp_leds = m_mode ? nios_leds : ((p < m_dq) ? 8'hFF : 8'h00);
        if (p == PERIOD - 1) begin
            // Mode flips only if the settled switch disagreed on this and the previous edge.
            if (m_stable != m_mode && m_prev_stable != m_mode) m_mode = m_stable;
            m_dq = int'(duty);
        end
        m_prev_stable = m_stable;
        flip = (sync_q.size() >= DB);
        for (int i = 0; i < DB; i++) begin
            if (flip && sync_q[sync_q.size()-1-i] == m_stable) flip = 1'b0;
        end
        if (flip) m_stable = !m_stable;
        m_edges++;
        exp_mode = m_mode;
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        n_checks++;
        if (leds !== 8'h00 || pwm_out !== 1'b0 || period_start !== 1'b0 || mode !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: leds=%h pwm=%b ps=%b mode=%b, want 00/0/0/0", leds, pwm_out, period_start, mode);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_pwm_basic();
        int highs = 0;
        int starts = 0;
        duty = 4'd4; sw_sel = 1'b0;
        for (int c = 0; c < 3 * PERIOD; c++) begin
            cycle();
            highs += int'(pwm_out);
            starts += int'(period_start);
            n_checks++;
            if (leds !== exp_leds || pwm_out !== exp_pwm || period_start !== exp_ps || mode !== exp_mode) begin
                n_fail++;
                $display("FAIL pwm_basic c%0d: got %h/%b/%b/%b want %h/%b/%b/%b", c, leds, pwm_out, period_start, mode, exp_leds, exp_pwm, exp_ps, exp_mode);
            end
        end
        n_checks++;
        if (highs != 8 || starts != 3) begin
            n_fail++;
            $display("FAIL pwm_basic_counts: highs=%0d starts=%0d, want 8 and 3", highs, starts);
        end
    endtask

    task automatic test_duty_edges();
        int dset[2] = '{0, 15};
        for (int k = 0; k < 2; k++) begin
            int highs = 0;
            duty = PW'(dset[k]);
            for (int c = 0; c < 2 * PERIOD; c++) begin
                cycle();
                if (c >= PERIOD) highs += int'(pwm_out);
                n_checks++;
                if (leds !== exp_leds || pwm_out !== exp_pwm || period_start !== exp_ps || mode !== exp_mode) begin
                    n_fail++;
                    $display("FAIL duty_edge d%0d c%0d: got %h/%b/%b/%b want %h/%b/%b/%b", dset[k], c, leds, pwm_out, period_start, mode, exp_leds, exp_pwm, exp_ps, exp_mode);
                end
            end
            n_checks++;
            if (highs != dset[k]) begin
                n_fail++;
                $display("FAIL duty_edge_count: duty=%0d highs=%0d want %0d", dset[k], highs, dset[k]);
            end
        end
    endtask

    task automatic test_mid_change();
        int h_cur = 0;
        int h_next = 0;
        duty = 4'd4;
        for (int c = 0; c < 3 * PERIOD; c++) begin
            if (c == PERIOD + 8) duty = 4'd10;
            cycle();
            if (c >= PERIOD && c < 2 * PERIOD) h_cur += int'(pwm_out);
            if (c >= 2 * PERIOD) h_next += int'(pwm_out);
            n_checks++;
            if (leds !== exp_leds || pwm_out !== exp_pwm || period_start !== exp_ps || mode !== exp_mode) begin
                n_fail++;
                $display("FAIL mid_change c%0d: got %h/%b/%b/%b want %h/%b/%b/%b", c, leds, pwm_out, period_start, mode, exp_leds, exp_pwm, exp_ps, exp_mode);
            end
        end
        n_checks++;
        if (h_cur != 4 || h_next != 10) begin
            n_fail++;
            $display("FAIL mid_change_counts: cur=%0d next=%0d, want 4 and 10", h_cur, h_next);
        end
    endtask

    task automatic test_debounce_glitch();
        nios_leds = 8'hA5; duty = 4'd4;
        for (int c = 0; c < 40; c++) begin
            sw_sel = (c < 2) ? 1'b1 : 1'b0;
            cycle();
            n_checks++;
            if (leds !== exp_leds || pwm_out !== exp_pwm || period_start !== exp_ps || mode !== exp_mode) begin
                n_fail++;
                $display("FAIL glitch c%0d: got %h/%b/%b/%b want %h/%b/%b/%b", c, leds, pwm_out, period_start, mode, exp_leds, exp_pwm, exp_ps, exp_mode);
            end
        end
        n_checks++;
        if (mode !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_mode: mode=%b want 0", mode);
        end
    endtask

    task automatic test_switch_to_nios();
        bit seen = 1'b0;
        sw_sel = 1'b1; nios_leds = 8'hA5; duty = 4'd4;
        for (int c = 0; c < 5 * PERIOD && !seen; c++) begin
            cycle();
            n_checks++;
            if (leds !== exp_leds || pwm_out !== exp_pwm || period_start !== exp_ps || mode !== exp_mode) begin
                n_fail++;
                $display("FAIL to_nios c%0d: got %h/%b/%b/%b want %h/%b/%b/%b", c, leds, pwm_out, period_start, mode, exp_leds, exp_pwm, exp_ps, exp_mode);
            end
            if (leds !== 8'h00 && leds !== 8'hFF && leds !== 8'hA5) begin
                n_checks++; n_fail++;
                $display("FAIL to_nios_glitch_word: leds=%h want 00, FF or A5", leds);
            end
            if (mode === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL to_nios_timeout: mode=%b want 1 within %0d cycles", mode, 5 * PERIOD);
        end else begin
            cycle();
            if (period_start !== 1'b1 || leds !== 8'hA5) begin
                n_fail++;
                $display("FAIL to_nios_apply: ps=%b leds=%h want 1 and a5", period_start, leds);
            end
        end
    endtask

    task automatic test_nios_bounce_back();
        while (m_edges % PERIOD != 0) cycle();
        for (int c = 0; c < 40; c++) begin
            sw_sel = (c < 6) ? 1'b0 : 1'b1;
            nios_leds = 8'($urandom);
            cycle();
            n_checks++;
            if (leds !== exp_leds || pwm_out !== exp_pwm || period_start !== exp_ps || mode !== exp_mode || mode !== 1'b1) begin
                n_fail++;
                $display("FAIL bounce_back c%0d: got %h/%b/%b/%b want %h/%b/%b/1", c, leds, pwm_out, period_start, mode, exp_leds, exp_pwm, exp_ps);
            end
        end
    endtask

    task automatic test_reset_mid();
        while (m_edges % PERIOD != 4) cycle();
        sw_sel = 1'b0;
        for (int c = 0; c < 3; c++) cycle();
        reset = 1'b1;
        #1;
        n_checks++;
        if (leds !== 8'h00 || pwm_out !== 1'b0 || period_start !== 1'b0 || mode !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_async: got %h/%b/%b/%b want 00/0/0/0", leds, pwm_out, period_start, mode);
        end
        model_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        cycle();
        n_checks++;
        if (period_start !== 1'b1 || mode !== 1'b0 || exp_ps !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_release: ps=%b mode=%b want 1 and 0", period_start, mode);
        end
        for (int c = 0; c < 24; c++) begin
            cycle();
            n_checks++;
            if (leds !== exp_leds || pwm_out !== exp_pwm || period_start !== exp_ps || mode !== exp_mode) begin
                n_fail++;
                $display("FAIL reset_mid_after c%0d: got %h/%b/%b/%b want %h/%b/%b/%b", c, leds, pwm_out, period_start, mode, exp_leds, exp_pwm, exp_ps, exp_mode);
            end
        end
    endtask

    task automatic test_random();
        int hold = 0;
        for (int c = 0; c < 600; c++) begin
            if (hold == 0) begin
                sw_sel = ~sw_sel;
                hold = int'($urandom_range(1, 40));
            end
            hold--;
            if ($urandom_range(0, 7) == 0) duty = PW'($urandom);
            nios_leds = 8'($urandom);
            cycle();
            n_checks++;
            if (leds !== exp_leds || pwm_out !== exp_pwm || period_start !== exp_ps || mode !== exp_mode) begin
                n_fail++;
                $display("FAIL random c%0d: got %h/%b/%b/%b want %h/%b/%b/%b", c, leds, pwm_out, period_start, mode, exp_leds, exp_pwm, exp_ps, exp_mode);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_pwm_basic();
        test_duty_edges();
        test_mid_change();
        test_debounce_glitch();
        test_switch_to_nios();
        test_nios_bounce_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
